// File: rtl/minibyte2_pkg.sv
// Shared encodings for the minibyte2 accumulator core: opcodes, FSM state codes
// and debug readout selects.
package minibyte2_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_BZ  = 4'hD;
  localparam logic [3:0] OP_BN  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_OPND   = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [2:0] DBG_ADDR   = 3'd0;
  localparam logic [2:0] DBG_A      = 3'd1;
  localparam logic [2:0] DBG_M      = 3'd2;
  localparam logic [2:0] DBG_PC     = 3'd3;
  localparam logic [2:0] DBG_IR     = 3'd4;
  localparam logic [2:0] DBG_FLAGS  = 3'd5;
  localparam logic [2:0] DBG_STATE  = 3'd6;
  localparam logic [2:0] DBG_RETCNT = 3'd7;

endpackage

// File: rtl/minibyte2_alu.sv
// Combinational accumulator ALU; LDI/LDA pass the memory operand through so every
// A-writing instruction shares one result and flag path.
module minibyte2_alu
  import minibyte2_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n
);

  // Result select per opcode; non-A-writing opcodes simply return A
  always_comb begin
    result = a;
    case (op)
      OP_LDI, OP_LDA: result = b;
      OP_ADD:         result = a + b;
      OP_SUB:         result = a - b;
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_NOT:         result = ~a;
      OP_SHL:         result = {a[DATA_W-2:0], 1'b0};
      OP_SHR:         result = {1'b0, a[DATA_W-1:1]};
      default:        result = a;
    endcase
  end

  assign z = (result == {DATA_W{1'b0}});
  assign n = result[DATA_W-1];

endmodule

// File: rtl/minibyte2_cpu.sv
// minibyte2 accumulator CPU core: registers, multi-cycle control FSM, req/ready
// memory handshake, retired-instruction counter and debug readout.
module minibyte2_cpu
  import minibyte2_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ena_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  input  logic              mem_ready_in,
  input  logic [2:0]        dbg_sel_in,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  output logic              drive_out,
  output logic              halted_out,
  output logic [DATA_W-1:0] dbg_out
);

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] a_r, m_r, ir_r, retcnt_r;
  logic              z_r, n_r;

  logic [3:0]        opcode_s;
  logic              req_s, we_s, done_s;
  logic [ADDR_W-1:0] addr_s, pc_inc_s, operand_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_z_s, alu_n_s;

  assign opcode_s  = ir_r[3:0];
  assign pc_inc_s  = pc_r + ADDR_W'(1'b1);
  assign operand_s = mem_rdata_in[ADDR_W-1:0];

  minibyte2_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_r),
    .b      (mem_rdata_in),
    .op     (opcode_s),
    .result (alu_res_s),
    .z      (alu_z_s),
    .n      (alu_n_s)
  );

  // Per-state memory request decode; only FETCH is gated by ena_in
  always_comb begin
    req_s  = 1'b0;
    we_s   = 1'b0;
    addr_s = pc_r;
    case (state_r)
      ST_FETCH: req_s = ena_in;
      ST_OPND:  req_s = 1'b1;
      ST_EXEC: begin
        req_s  = 1'b1;
        we_s   = (opcode_s == OP_STA);
        addr_s = m_r[ADDR_W-1:0];
      end
      default: req_s = 1'b0;
    endcase
  end

  // Qualifying with rst_in drops the request the instant reset asserts, even with ena_in high
  assign mem_req_out   = req_s & rst_in;
  assign mem_we_out    = we_s & mem_req_out;
  assign mem_addr_out  = mem_req_out ? addr_s : {ADDR_W{1'b0}};
  assign mem_wdata_out = a_r;
  assign drive_out     = mem_req_out & mem_we_out;
  assign halted_out    = (state_r == ST_HALT);
  assign done_s        = mem_req_out & mem_ready_in;

  // Architectural registers and control FSM
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r  <= ST_FETCH;
      pc_r     <= RESET_PC;
      a_r      <= {DATA_W{1'b0}};
      m_r      <= {DATA_W{1'b0}};
      ir_r     <= {DATA_W{1'b0}};
      retcnt_r <= {DATA_W{1'b0}};
      z_r      <= 1'b0;
      n_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: if (done_s) begin
          ir_r    <= mem_rdata_in;
          pc_r    <= pc_inc_s;
          state_r <= ST_DECODE;
        end
        ST_DECODE: case (opcode_s)
          OP_NOP: begin
            retcnt_r <= retcnt_r + DATA_W'(1'b1);
            state_r  <= ST_FETCH;
          end
          OP_NOT, OP_SHL, OP_SHR: begin
            a_r      <= alu_res_s;
            z_r      <= alu_z_s;
            n_r      <= alu_n_s;
            retcnt_r <= retcnt_r + DATA_W'(1'b1);
            state_r  <= ST_FETCH;
          end
          OP_HLT: begin
            retcnt_r <= retcnt_r + DATA_W'(1'b1);
            state_r  <= ST_HALT;
          end
          default: state_r <= ST_OPND;
        endcase
        ST_OPND: if (done_s) begin
          case (opcode_s)
            OP_LDI: begin
              a_r      <= alu_res_s;
              z_r      <= alu_z_s;
              n_r      <= alu_n_s;
              pc_r     <= pc_inc_s;
              retcnt_r <= retcnt_r + DATA_W'(1'b1);
              state_r  <= ST_FETCH;
            end
            OP_JMP: begin
              pc_r     <= operand_s;
              retcnt_r <= retcnt_r + DATA_W'(1'b1);
              state_r  <= ST_FETCH;
            end
            OP_BZ, OP_BN: begin
              pc_r     <= ((opcode_s == OP_BZ) ? z_r : n_r) ? operand_s : pc_inc_s;
              retcnt_r <= retcnt_r + DATA_W'(1'b1);
              state_r  <= ST_FETCH;
            end
            default: begin
              m_r     <= mem_rdata_in;
              pc_r    <= pc_inc_s;
              state_r <= ST_EXEC;
            end
          endcase
        end
        ST_EXEC: if (done_s) begin
          if (opcode_s != OP_STA) begin
            a_r <= alu_res_s;
            z_r <= alu_z_s;
            n_r <= alu_n_s;
          end
          retcnt_r <= retcnt_r + DATA_W'(1'b1);
          state_r  <= ST_FETCH;
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  // Debug readout, zero-extended to DATA_W
  always_comb begin
    dbg_out = {DATA_W{1'b0}};
    case (dbg_sel_in)
      DBG_ADDR:   dbg_out = DATA_W'(mem_addr_out);
      DBG_A:      dbg_out = a_r;
      DBG_M:      dbg_out = m_r;
      DBG_PC:     dbg_out = DATA_W'(pc_r);
      DBG_IR:     dbg_out = ir_r;
      DBG_FLAGS:  dbg_out = DATA_W'({n_r, z_r});
      DBG_STATE:  dbg_out = DATA_W'(state_r);
      DBG_RETCNT: dbg_out = retcnt_r;
      default:    dbg_out = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_minibyte2_cpu.sv
// Self-checking bench for minibyte2_cpu: 8-bit core with a wait-state memory
// responder and write scoreboard, plus a 16/12-bit core for width/wrap checks.
module tb_minibyte2_cpu;
  import minibyte2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ena, mem_ready, mem_req, mem_we, drive, halted;
  logic [2:0] dbg_sel;
  logic [7:0] mem_rdata, mem_addr, mem_wdata, dbg;
  logic [7:0] mem8 [256];

  logic        rst_w, ena_w, ready_w, req_w, we_w, drive_w, halted_w;
  logic [2:0]  dbg_sel_w;
  logic [15:0] rdata_w, wdata_w, dbg_w;
  logic [11:0] addr_w;
  logic [15:0] memw [4096];

  int errors = 0;
  int checks = 0;
  int wait_n = 0;
  int wr_count = 0;
  logic [15:0] exp_wr_q[$];

  assign mem_rdata = mem8[mem_addr];
  assign rdata_w   = memw[addr_w];

  minibyte2_cpu #(.DATA_W(8), .ADDR_W(8)) u_dut (
    .clk_in(clk), .rst_in(rst), .ena_in(ena), .mem_rdata_in(mem_rdata),
    .mem_ready_in(mem_ready), .dbg_sel_in(dbg_sel), .mem_req_out(mem_req),
    .mem_we_out(mem_we), .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata),
    .drive_out(drive), .halted_out(halted), .dbg_out(dbg)
  );

  minibyte2_cpu #(.DATA_W(16), .ADDR_W(12)) u_dut_w (
    .clk_in(clk), .rst_in(rst_w), .ena_in(ena_w), .mem_rdata_in(rdata_w),
    .mem_ready_in(ready_w), .dbg_sel_in(dbg_sel_w), .mem_req_out(req_w),
    .mem_we_out(we_w), .mem_addr_out(addr_w), .mem_wdata_out(wdata_w),
    .drive_out(drive_w), .halted_out(halted_w), .dbg_out(dbg_w)
  );

  // Memory responder: inserts wait_n wait states per access, checks the request
  // is held stable, commits writes and pops the expected-write scoreboard.
  bit         in_txn = 1'b0;
  int         wait_cnt = 0;
  logic [7:0] cap_addr, cap_wdata;
  logic       cap_we;
  logic [15:0] exp_w;
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_txn = 1'b0; mem_ready = 1'b0; wait_cnt = 0;
      end else if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1'b1; wait_cnt = 0;
          cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
        end else begin
          checks++;
          if ({mem_addr, mem_we, mem_wdata} !== {cap_addr, cap_we, cap_wdata}) begin
            errors++;
            $display("FAIL hold_stable: addr/we/wdata=%h/%b/%h required %h/%b/%h",
                     mem_addr, mem_we, mem_wdata, cap_addr, cap_we, cap_wdata);
          end
        end
        if (wait_cnt >= wait_n) begin
          mem_ready = 1'b1;
          in_txn = 1'b0;
          if (mem_we) begin
            mem8[mem_addr] = mem_wdata;
            wr_count++;
            checks++;
            if (exp_wr_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_write: addr=%h data=%h required no write", mem_addr, mem_wdata);
            end else begin
              exp_w = exp_wr_q.pop_front();
              if ({mem_addr, mem_wdata} !== exp_w) begin
                errors++;
                $display("FAIL write_data: addr/data=%h/%h required %h/%h",
                         mem_addr, mem_wdata, exp_w[15:8], exp_w[7:0]);
              end
            end
          end
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b1;
        in_txn = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_read(input logic [2:0] s, output logic [7:0] v);
    dbg_sel = s;
    #1;
    v = dbg;
  endtask

  task automatic dbg_read_w(input logic [2:0] s, output logic [15:0] v);
    dbg_sel_w = s;
    #1;
    v = dbg_w;
  endtask

  task automatic fill_mem;
    for (int i = 0; i < 256; i++) mem8[i] = 8'h0F;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic run_halt(input int maxc, output int cyc);
    cyc = 0;
    while (!halted && cyc < maxc) begin
      tick();
      cyc++;
    end
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL halt_timeout: halted=%b after %0d cycles required 1", halted, cyc);
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    ena = 1'b1; wait_n = 0; rst = 1'b0;
    tick();
    checks++;
    if ({mem_req, mem_we, drive, halted, mem_addr, mem_wdata} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: req/we/drive/halt/addr/wdata=%b%b%b%b/%h/%h required all 0",
               mem_req, mem_we, drive, halted, mem_addr, mem_wdata);
    end
    dbg_read(DBG_A, v);      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_a: got %h required 00", v); end
    dbg_read(DBG_PC, v);     checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h required 00", v); end
    dbg_read(DBG_STATE, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_state: got %h required 00", v); end
    dbg_read(DBG_RETCNT, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_retcnt: got %h required 00", v); end
    dbg_read(DBG_FLAGS, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_flags: got %h required 00", v); end
  endtask

  task automatic test_zero_wait_program;
    logic [7:0] v;
    int cyc;
    fill_mem();
    mem8[0] = 8'h01; mem8[1] = 8'h05; mem8[2] = 8'h04; mem8[3] = 8'h10;
    mem8[4] = 8'h0D; mem8[5] = 8'h20; mem8[8'h10] = 8'hFB; mem8[8'h20] = 8'h0F;
    ena = 1'b1; wait_n = 0;
    do_reset();
    run_halt(100, cyc);
    checks++; if (cyc !== 12) begin errors++; $display("FAIL zw_latency: got %0d cycles required 12", cyc); end
    dbg_read(DBG_A, v);      checks++; if (v !== 8'h00) begin errors++; $display("FAIL zw_a: got %h required 00", v); end
    dbg_read(DBG_FLAGS, v);  checks++; if (v !== 8'h01) begin errors++; $display("FAIL zw_flags: got %h required 01", v); end
    dbg_read(DBG_PC, v);     checks++; if (v !== 8'h21) begin errors++; $display("FAIL zw_pc: got %h required 21", v); end
    dbg_read(DBG_RETCNT, v); checks++; if (v !== 8'h04) begin errors++; $display("FAIL zw_retcnt: got %h required 04", v); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_req: got %b required 0", mem_req); end
  endtask

  task automatic test_wait_states;
    int cyc, wr0;
    fill_mem();
    mem8[0] = 8'h01; mem8[1] = 8'h5A; mem8[2] = 8'h03; mem8[3] = 8'h40; mem8[4] = 8'h0F;
    ena = 1'b1; wait_n = 2; wr0 = wr_count;
    exp_wr_q.push_back({8'h40, 8'h5A});
    do_reset();
    run_halt(200, cyc);
    checks++; if (cyc !== 21) begin errors++; $display("FAIL ws_latency: got %0d cycles required 21", cyc); end
    checks++; if (wr_count - wr0 !== 1) begin errors++; $display("FAIL ws_write_count: got %0d required 1", wr_count - wr0); end
    checks++; if (exp_wr_q.size() !== 0) begin errors++; $display("FAIL ws_pending: got %0d required 0", exp_wr_q.size()); end
    checks++; if (mem8[8'h40] !== 8'h5A) begin errors++; $display("FAIL ws_mem: got %h required 5A", mem8[8'h40]); end
    wait_n = 0;
  endtask

  task automatic test_sub_branch;
    logic [7:0] v;
    int cyc;
    fill_mem();
    mem8[0] = 8'h01; mem8[1] = 8'h03; mem8[2] = 8'h05; mem8[3] = 8'h50;
    mem8[4] = 8'h03; mem8[5] = 8'h60; mem8[6] = 8'h0E; mem8[7] = 8'h30;
    mem8[8'h30] = 8'h0D; mem8[8'h31] = 8'h40; mem8[8'h50] = 8'h05;
    ena = 1'b1; wait_n = 0;
    exp_wr_q.push_back({8'h60, 8'hFE});
    do_reset();
    run_halt(100, cyc);
    checks++; if (cyc !== 19) begin errors++; $display("FAIL sb_latency: got %0d cycles required 19", cyc); end
    dbg_read(DBG_A, v);      checks++; if (v !== 8'hFE) begin errors++; $display("FAIL sb_a: got %h required FE", v); end
    dbg_read(DBG_FLAGS, v);  checks++; if (v !== 8'h02) begin errors++; $display("FAIL sb_flags: got %h required 02", v); end
    dbg_read(DBG_PC, v);     checks++; if (v !== 8'h33) begin errors++; $display("FAIL sb_pc: got %h required 33", v); end
    dbg_read(DBG_RETCNT, v); checks++; if (v !== 8'h06) begin errors++; $display("FAIL sb_retcnt: got %h required 06", v); end
    checks++; if (exp_wr_q.size() !== 0) begin errors++; $display("FAIL sb_pending: got %0d required 0", exp_wr_q.size()); end
  endtask

  task automatic test_ena;
    logic [7:0] v;
    int idle_req, cyc;
    bit seen;
    fill_mem();
    mem8[0] = 8'h02; mem8[1] = 8'h70; mem8[8'h70] = 8'h99;
    ena = 1'b0; wait_n = 0;
    do_reset();
    idle_req = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req !== 1'b0) idle_req++;
    end
    checks++; if (idle_req !== 0) begin errors++; $display("FAIL ena_idle_req: got %0d req cycles required 0", idle_req); end
    dbg_read(DBG_PC, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL ena_idle_pc: got %h required 00", v); end
    ena = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      dbg_read(DBG_STATE, v);
      if (v === 8'h03) seen = 1'b1;
    end
    ena = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL ena_exec_seen: got 0 required 1"); end
    tick();
    dbg_read(DBG_STATE, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL ena_state: got %h required 00", v); end
    dbg_read(DBG_A, v);      checks++; if (v !== 8'h99) begin errors++; $display("FAIL ena_lda_a: got %h required 99", v); end
    dbg_read(DBG_RETCNT, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL ena_retcnt: got %h required 01", v); end
    idle_req = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req !== 1'b0) idle_req++;
    end
    checks++; if (idle_req !== 0) begin errors++; $display("FAIL ena_wait_req: got %0d req cycles required 0", idle_req); end
    dbg_read(DBG_PC, v); checks++; if (v !== 8'h02) begin errors++; $display("FAIL ena_wait_pc: got %h required 02", v); end
    ena = 1'b1;
    run_halt(20, cyc);
    dbg_read(DBG_RETCNT, v); checks++; if (v !== 8'h02) begin errors++; $display("FAIL ena_final_retcnt: got %h required 02", v); end
  endtask

  task automatic test_reset_mid_sta;
    logic [7:0] v;
    int cyc, wr0;
    bit seen;
    fill_mem();
    mem8[0] = 8'h01; mem8[1] = 8'h5A; mem8[2] = 8'h03; mem8[3] = 8'h40; mem8[4] = 8'h0F;
    ena = 1'b1; wait_n = 2;
    do_reset();
    wr0 = wr_count;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      dbg_read(DBG_STATE, v);
      if (v === 8'h03) seen = 1'b1;
    end
    checks++; if (!seen || drive !== 1'b1) begin errors++; $display("FAIL mid_exec_drive: seen=%b drive=%b required 1/1", seen, drive); end
    rst = 1'b0;
    #1;
    checks++; if ({mem_req, drive} !== 2'b00) begin errors++; $display("FAIL mid_reset_drop: req/drive=%b%b required 00", mem_req, drive); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL mid_first_fetch: req/addr=%b/%h required 1/00", mem_req, mem_addr); end
    dbg_read(DBG_A, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL mid_a: got %h required 00", v); end
    exp_wr_q.push_back({8'h40, 8'h5A});
    run_halt(200, cyc);
    checks++; if (wr_count - wr0 !== 1) begin errors++; $display("FAIL mid_write_count: got %0d required 1", wr_count - wr0); end
    wait_n = 0;
  endtask

  task automatic test_wide;
    logic [15:0] v;
    for (int i = 0; i < 4096; i++) memw[i] = 16'h000F;
    memw[0] = 16'h0001; memw[1] = 16'h8000; memw[2] = 16'h000C; memw[3] = 16'h0FFF;
    memw[12'hFFF] = 16'h0000;
    ena_w = 1'b1; rst_w = 1'b0;
    tick(); tick();
    rst_w = 1'b1;
    repeat (3) tick();
    dbg_read_w(DBG_A, v);     checks++; if (v !== 16'h8000) begin errors++; $display("FAIL w_a: got %h required 8000", v); end
    dbg_read_w(DBG_FLAGS, v); checks++; if (v !== 16'h0002) begin errors++; $display("FAIL w_flags: got %h required 0002", v); end
    repeat (3) tick();
    dbg_read_w(DBG_PC, v);    checks++; if (v !== 16'h0FFF) begin errors++; $display("FAIL w_jmp_pc: got %h required 0FFF", v); end
    dbg_read_w(DBG_STATE, v); checks++; if (v !== 16'h0000) begin errors++; $display("FAIL w_state0: got %h required 0000", v); end
    checks++; if (addr_w !== 12'hFFF) begin errors++; $display("FAIL w_fetch_fff: got %h required FFF", addr_w); end
    tick();
    dbg_read_w(DBG_STATE, v); checks++; if (v !== 16'h0001) begin errors++; $display("FAIL w_state1: got %h required 0001", v); end
    dbg_read_w(DBG_PC, v);    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL w_pc_wrap: got %h required 0000", v); end
    tick();
    dbg_read_w(DBG_STATE, v); checks++; if (v !== 16'h0000) begin errors++; $display("FAIL w_state_back: got %h required 0000", v); end
    checks++; if ({req_w, addr_w} !== {1'b1, 12'h000}) begin errors++; $display("FAIL w_fetch_000: req/addr=%b/%h required 1/000", req_w, addr_w); end
    rst_w = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; dbg_sel = 3'd0;
    rst_w = 1'b0; ena_w = 1'b0; dbg_sel_w = 3'd0; ready_w = 1'b1;
    fill_mem();
    for (int i = 0; i < 4096; i++) memw[i] = 16'h000F;
    test_reset();
    test_zero_wait_program();
    test_wait_states();
    test_sub_branch();
    test_ena();
    test_reset_mid_sta();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
